fir_mac_engine: RTL and testbench

- Per-sample, time-multiplexed FIR multiply-accumulate engine.
- Each instance owns one TAPS-long section of the filter: its delay line plus its coefficients.
- On each 600 kHz sample strobe it shifts in the new input and accumulates TAPS products serially at 12 MHz.
- It then presents a saturated 16-bit partial sum on oMac with a one-cycle oEnDelay strobe. Four instances feed the MAC-sum stage (iMac1..4 / iEnDelay).

---
 rtl/fir_mac_engine_if.sv | 25 ++
 rtl/fir_mac_engine.sv | 180 ++++++++++++++++++
 tb/tb_fir_mac_engine.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_engine_if.sv
// Sample/coefficient/result bundle of one FIR MAC section.
// The master side drives samples and coefficient writes; the slave side is the engine.
interface fir_mac_engine_if #(
   parameter int DW = 16
);
   logic                 iEnSample600k;
   logic signed [DW-1:0] iFirIn;
   logic                 iCoeffWe;
   logic [3:0]           iCoeffAddr;
   logic signed [DW-1:0] iCoeffData;
   logic signed [DW-1:0] oMac;
   logic                 oEnDelay;
   logic                 oBusy;
   logic                 oOverrun;

   modport master (
      output iEnSample600k, iFirIn, iCoeffWe, iCoeffAddr, iCoeffData,
      input  oMac, oEnDelay, oBusy, oOverrun
   );

   modport slave (
      input  iEnSample600k, iFirIn, iCoeffWe, iCoeffAddr, iCoeffData,
      output oMac, oEnDelay, oBusy, oOverrun
   );
endinterface

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR section: one TAPS-long delay line and coefficient set,
// one multiply-accumulate per clock, saturated partial sum with a one-cycle strobe.
// A single pending slot absorbs one sample that arrives while a MAC is in flight.
module fir_mac_engine #(
   parameter int TAPS  = 10,
   parameter int DW    = 16,
   parameter int ACCW  = 36,
   parameter int SHIFT = 15
) (
   input logic              iClk12M,
   input logic              iRst,
   fir_mac_engine_if.slave  bus
);
   localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [KW-1:0] LAST_IDX = KW'(TAPS - 1);
   localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(64'sd1 <<< (DW - 1)));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_r;
   logic signed [DW-1:0]   tap_r [TAPS];
   logic signed [DW-1:0]   coef_r [TAPS];
   logic signed [ACCW-1:0] acc_r;
   logic [KW-1:0]          tapIdx_r;
   logic signed [DW-1:0]   pend_r;
   logic                   pendValid_r;
   logic signed [DW-1:0]   mac_r;
   logic                   enDelay_r;
   logic                   busy_r;
   logic                   overrun_r;

   logic                   shift_s;
   logic signed [DW-1:0]   shiftIn_s;
   logic                   coefWrOk_s;
   logic signed [DW-1:0]   tapSel_s;
   logic signed [DW-1:0]   coefSel_s;
   logic signed [2*DW-1:0] prod_s;
   logic signed [ACCW-1:0] accNext_s;

   // Arithmetic right shift (floor) then clamp to the signed DW-bit range.
   function automatic logic signed [DW-1:0] satShift(input logic signed [ACCW-1:0] a);
      logic signed [ACCW-1:0] s;
      logic signed [DW-1:0]   res;
      s = a >>> SHIFT;
      if (s > SAT_MAX) begin
         res = SAT_MAX[DW-1:0];
      end else if (s < SAT_MIN) begin
         res = SAT_MIN[DW-1:0];
      end else begin
         res = s[DW-1:0];
      end
      return res;
   endfunction

   // Decide when the delay line advances and which sample (live or pending) enters it.
   always_comb begin
      shift_s   = 1'b0;
      shiftIn_s = bus.iFirIn;
      case (state_r)
         IDLE: begin
            shift_s = bus.iEnSample600k;
         end
         DONE: begin
            shift_s = pendValid_r || bus.iEnSample600k;
            if (pendValid_r) begin
               shiftIn_s = pend_r;
            end else begin
               shiftIn_s = bus.iFirIn;
            end
         end
         default: begin
            shift_s = 1'b0;
         end
      endcase
      coefWrOk_s = bus.iCoeffWe && (state_r == IDLE) && ({28'd0, bus.iCoeffAddr} < 32'(TAPS));
      tapSel_s   = tap_r[tapIdx_r];
      coefSel_s  = coef_r[tapIdx_r];
      prod_s     = (2*DW)'(tapSel_s) * (2*DW)'(coefSel_s);
      accNext_s  = acc_r + ACCW'(prod_s);
   end

   // Delay line: the newest sample enters tap 0, older ones move one place down.
   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         for (int k = 0; k < TAPS; k++) tap_r[k] <= '0;
      end else if (shift_s) begin
         for (int k = TAPS - 1; k > 0; k--) tap_r[k] <= tap_r[k-1];
         tap_r[0] <= shiftIn_s;
      end
   end

   // Coefficient store: writable only while idle; a write alongside a strobe still lands first.
   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         for (int k = 0; k < TAPS; k++) coef_r[k] <= '0;
      end else if (coefWrOk_s) begin
         coef_r[KW'(bus.iCoeffAddr)] <= bus.iCoeffData;
      end
   end

   // Sequencer: sample intake, serial MAC, result publication, pending slot and status flags.
   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         tapIdx_r    <= '0;
         pend_r      <= '0;
         pendValid_r <= 1'b0;
         mac_r       <= '0;
         enDelay_r   <= 1'b0;
         busy_r      <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         enDelay_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.iEnSample600k) begin
                  acc_r    <= '0;
                  tapIdx_r <= '0;
                  busy_r   <= 1'b1;
                  state_r  <= MAC;
               end else begin
                  busy_r   <= 1'b0;
               end
            end
            MAC: begin
               acc_r <= accNext_s;
               if (tapIdx_r == LAST_IDX) begin
                  // Publish the result that includes this final product.
                  tapIdx_r  <= '0;
                  mac_r     <= satShift(accNext_s);
                  enDelay_r <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  tapIdx_r  <= tapIdx_r + KW'(1);
               end
               if (bus.iEnSample600k) begin
                  pend_r      <= bus.iFirIn;
                  pendValid_r <= 1'b1;
                  if (pendValid_r) begin
                     overrun_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (pendValid_r || bus.iEnSample600k) begin
                  // The waiting (or just-arrived) sample has entered the delay line.
                  acc_r    <= '0;
                  tapIdx_r <= '0;
                  state_r  <= MAC;
                  if (pendValid_r && bus.iEnSample600k) begin
                     pend_r      <= bus.iFirIn;
                     pendValid_r <= 1'b1;
                  end else begin
                     pendValid_r <= 1'b0;
                  end
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               pendValid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.oMac     = mac_r;
   assign bus.oEnDelay = enDelay_r;
   assign bus.oBusy    = busy_r;
   assign bus.oOverrun = overrun_r;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: impulse vector table, cycle-exact timelines for
// latency / pending / overrun, coefficient lockout, async reset, saturation and
// randomized samples checked against a sum-of-products reference.
`timescale 1ns/1ps
module tb_fir_mac_engine;
   localparam int TAPS = 10;
   localparam int DW   = 16;

   logic iClk12M = 1'b0;
   logic iRst    = 1'b1;

   fir_mac_engine_if #(.DW(DW)) bus();

   fir_mac_engine #(.TAPS(TAPS), .DW(DW), .ACCW(36), .SHIFT(15)) dut (
      .iClk12M (iClk12M),
      .iRst    (iRst),
      .bus     (bus)
   );

   always #42 iClk12M = ~iClk12M;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference: coefficient table, sample history (index 0 newest), last published value.
   logic signed [15:0] mCoef [TAPS];
   logic signed [15:0] mHist [TAPS];
   logic [15:0]        mLastMac;

   typedef struct {
      logic [15:0] x;
      logic [15:0] expMac;
   } vec_t;
   vec_t imp [12];

   function automatic logic [15:0] modelOut();
      longint sum;
      sum = 0;
      for (int k = 0; k < TAPS; k++) sum += longint'(mHist[k]) * longint'(mCoef[k]);
      sum = sum >>> 15;
      if (sum > 32767) return 16'h7FFF;
      if (sum < -32768) return 16'h8000;
      return 16'(sum);
   endfunction

   task automatic modelPush(input logic [15:0] x);
      for (int k = TAPS - 1; k > 0; k--) mHist[k] = mHist[k-1];
      mHist[0] = x;
   endtask

   task automatic modelReset();
      for (int k = 0; k < TAPS; k++) begin
         mCoef[k] = 16'h0000;
         mHist[k] = 16'h0000;
      end
      mLastMac = 16'h0000;
   endtask

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
      end
   endtask

   // All tasks start and end 1 ns after a rising edge.
   task automatic writeCoef(input logic [3:0] a, input logic [15:0] d);
      bus.iCoeffWe   = 1'b1;
      bus.iCoeffAddr = a;
      bus.iCoeffData = d;
      @(posedge iClk12M); #1;
      bus.iCoeffWe   = 1'b0;
      if (int'(a) < TAPS) mCoef[a] = d;
   endtask

   // One sample from idle; optionally attempts a coefficient write (addr 3) mid-MAC.
   task automatic runSample(input logic [15:0] x, input logic [15:0] expMac,
                            input string nm, input bit busyWrite);
      bit seen;
      seen = 1'b0;
      bus.iEnSample600k = 1'b1;
      bus.iFirIn        = x;
      @(posedge iClk12M); #1;
      bus.iEnSample600k = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge iClk12M);
         if (bus.oEnDelay) begin
            seen = 1'b1;
            break;
         end
         @(posedge iClk12M); #1;
         bus.iCoeffWe   = busyWrite && (n == 3);
         bus.iCoeffAddr = 4'd3;
         bus.iCoeffData = 16'h1234;
      end
      bus.iCoeffWe = 1'b0;
      check({nm, "_pulse_seen"}, 16'(seen), 16'd1);
      if (seen) check({nm, "_mac"}, bus.oMac, expMac);
      mLastMac = expMac;
      @(posedge iClk12M); #1;
   endtask

   // Cycle-exact run: strobes at sAt (-1 unused), expected pulses at pAt with values pVal.
   task automatic timeline(input string nm, input int nCyc,
                           input int sAt [3], input logic [15:0] sVal [3],
                           input int pAt [2], input logic [15:0] pVal [2],
                           input int busyLo, input int busyHi, input int ovFrom);
      logic [15:0] held;
      held = mLastMac;
      for (int c = 0; c < nCyc; c++) begin
         int si;
         int pi;
         si = -1;
         pi = -1;
         for (int j = 0; j < 3; j++) if (sAt[j] == c) si = j;
         for (int j = 0; j < 2; j++) if (pAt[j] == c) pi = j;
         bus.iEnSample600k = (si >= 0);
         bus.iFirIn        = (si >= 0) ? sVal[si] : 16'h0000;
         @(negedge iClk12M);
         check($sformatf("%s_endelay_c%0d", nm, c), 16'(bus.oEnDelay), 16'(pi >= 0));
         if (pi >= 0) begin
            check($sformatf("%s_mac_c%0d", nm, c), bus.oMac, pVal[pi]);
            held = pVal[pi];
         end else begin
            check($sformatf("%s_hold_c%0d", nm, c), bus.oMac, held);
         end
         if (busyLo >= 0)
            check($sformatf("%s_busy_c%0d", nm, c), 16'(bus.oBusy), 16'((c >= busyLo) && (c <= busyHi)));
         if (ovFrom >= 0 && c != ovFrom - 1)
            check($sformatf("%s_overrun_c%0d", nm, c), 16'(bus.oOverrun), 16'(c >= ovFrom));
         @(posedge iClk12M); #1;
      end
      bus.iEnSample600k = 1'b0;
      mLastMac = held;
   endtask

   task automatic runImpulseTable(input string nm);
      for (int i = 0; i < 12; i++) begin
         modelPush(imp[i].x);
         runSample(imp[i].x, imp[i].expMac, $sformatf("%s_%0d", nm, i), 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sAt [3];
      logic [15:0] sVal [3];
      int          pAt [2];
      logic [15:0] pVal [2];
      logic [15:0] e1;
      logic [15:0] e2;
      int          cnt;

      for (int i = 0; i < 12; i++) begin
         imp[i].x      = (i == 0) ? 16'h4000 : 16'h0000;
         imp[i].expMac = (i < 10) ? 16'(16'h0080 * (i + 1)) : 16'h0000;
      end

      bus.iEnSample600k = 1'b0;
      bus.iFirIn        = 16'h0000;
      bus.iCoeffWe      = 1'b0;
      bus.iCoeffAddr    = 4'd0;
      bus.iCoeffData    = 16'h0000;
      modelReset();
      repeat (3) @(posedge iClk12M);
      #1 iRst = 1'b0;
      @(negedge iClk12M);
      check("reset_mac", bus.oMac, 16'h0000);
      check("reset_endelay", 16'(bus.oEnDelay), 16'd0);
      check("reset_busy", 16'(bus.oBusy), 16'd0);
      check("reset_overrun", 16'(bus.oOverrun), 16'd0);
      @(posedge iClk12M); #1;

      // Impulse response through coef[k] = 0x0100*(k+1).
      for (int k = 0; k < TAPS; k++) writeCoef(4'(k), 16'(16'h0100 * (k + 1)));
      runImpulseTable("impulse");

      // Latency from idle: pulse only at cycle 11, busy over cycles 1..11.
      modelPush(16'h4000);
      e1   = modelOut();
      sAt  = '{0, -1, -1};
      sVal = '{16'h4000, 16'h0000, 16'h0000};
      pAt  = '{11, -1};
      pVal = '{e1, 16'h0000};
      timeline("latency", 15, sAt, sVal, pAt, pVal, 1, 11, -1);
      check("latency_value", mLastMac, 16'h0080);

      // Coefficient write during MAC is ignored; then flush with zeros.
      modelPush(16'h0000);
      runSample(16'h0000, modelOut(), "lockout", 1'b1);
      for (int i = 0; i < 9; i++) begin
         modelPush(16'h0000);
         runSample(16'h0000, modelOut(), $sformatf("flush_%0d", i), 1'b0);
      end
      writeCoef(4'd12, 16'h7777);
      runImpulseTable("after_lockout");

      // Strobe during DONE with pending empty: processed right after, no overrun.
      modelPush(16'h1000);
      e1 = modelOut();
      modelPush(16'h0800);
      e2 = modelOut();
      sAt  = '{0, 11, -1};
      sVal = '{16'h1000, 16'h0800, 16'h0000};
      pAt  = '{11, 22};
      pVal = '{e1, e2};
      timeline("done_strobe", 26, sAt, sVal, pAt, pVal, -1, -1, 1000);

      // Back-to-back strobes at 0, 5, 7: sample at 5 is overwritten and dropped.
      modelPush(16'h4000);
      e1 = modelOut();
      modelPush(16'h2000);
      e2 = modelOut();
      sAt  = '{0, 5, 7};
      sVal = '{16'h4000, 16'h7000, 16'h2000};
      pAt  = '{11, 22};
      pVal = '{e1, e2};
      timeline("b2b", 26, sAt, sVal, pAt, pVal, -1, -1, 8);

      // Async reset in the middle of a MAC.
      bus.iEnSample600k = 1'b1;
      bus.iFirIn        = 16'h4000;
      @(posedge iClk12M); #1;
      bus.iEnSample600k = 1'b0;
      repeat (4) begin @(posedge iClk12M); #1; end
      iRst = 1'b1;
      #1;
      check("arst_mac", bus.oMac, 16'h0000);
      check("arst_busy", 16'(bus.oBusy), 16'd0);
      check("arst_overrun", 16'(bus.oOverrun), 16'd0);
      repeat (2) @(posedge iClk12M);
      #1 iRst = 1'b0;
      modelReset();
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge iClk12M);
         if (bus.oEnDelay) cnt++;
         @(posedge iClk12M); #1;
      end
      check("arst_no_pulse", 16'(cnt), 16'd0);
      modelPush(16'h4000);
      runSample(16'h4000, modelOut(), "arst_zero_coef", 1'b0);
      check("arst_zero_coef_const", mLastMac, 16'h0000);

      // Saturation in both directions.
      for (int k = 0; k < TAPS; k++) writeCoef(4'(k), 16'h7FFF);
      for (int i = 0; i < 10; i++) begin
         modelPush(16'h7FFF);
         runSample(16'h7FFF, modelOut(), $sformatf("sat_pos_%0d", i), 1'b0);
      end
      check("sat_pos_final", bus.oMac, 16'h7FFF);
      for (int i = 0; i < 10; i++) begin
         modelPush(16'h8000);
         runSample(16'h8000, modelOut(), $sformatf("sat_neg_%0d", i), 1'b0);
      end
      check("sat_neg_final", bus.oMac, 16'h8000);

      // Randomized samples, coefficient writes (some out of range) and busy writes.
      for (int i = 0; i < 40; i++) begin
         logic [15:0] x;
         if ($urandom_range(0, 1) == 1) writeCoef(4'($urandom_range(0, 15)), 16'($urandom));
         x = 16'($urandom);
         modelPush(x);
         runSample(x, modelOut(), $sformatf("rand_%0d", i), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) begin @(posedge iClk12M); #1; end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
